comparison_sequencer: RTL

Controller that owns the shared 4-bit comparison datapath (equal / greater / less-than / max behind a 2-bit operation select, 8-bit zero-extended result). It latches an operand pair on a start pulse and runs either one selected operation or a sweep of all four. It captures each result into registers and raises a one-cycle done pulse. It also checks result width and cross-operation consistency, flagging any violation on a sticky error output.

---
 rtl/comparison_pkg.sv | 24 ++
 rtl/comparison_checker.sv | 25 ++
 rtl/comparison_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/comparison_pkg.sv
// Shared encodings and widths for the comparison sequencer and its checker.
package comparison_pkg;

   localparam int OPERAND_W = 4;
   localparam int RESULT_W  = 8;

   localparam logic [1:0] OP_EQ  = 2'd0;
   localparam logic [1:0] OP_GT  = 2'd1;
   localparam logic [1:0] OP_LT  = 2'd2;
   localparam logic [1:0] OP_MAX = 2'd3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_EVAL  = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      EVAL  = ST_EVAL,
      CHECK = ST_CHECK,
      DONE  = ST_DONE
   } state_e;

endpackage

// File: rtl/comparison_checker.sv
// Cross-operation consistency check over the captured sweep results.
module comparison_checker
   import comparison_pkg::*;
(
   input  logic                 eq_flag,
   input  logic                 gt_flag,
   input  logic                 lt_flag,
   input  logic [OPERAND_W-1:0] max_val,
   input  logic [OPERAND_W-1:0] x,
   input  logic [OPERAND_W-1:0] y,
   output logic                 cons_err
);

   logic one_hot;

   always_comb begin
      one_hot  = ({eq_flag, gt_flag, lt_flag} == 3'b100) ||
                 ({eq_flag, gt_flag, lt_flag} == 3'b010) ||
                 ({eq_flag, gt_flag, lt_flag} == 3'b001);
      cons_err = !one_hot ||
                 (max_val != (gt_flag ? x : y)) ||
                 (eq_flag && (x != y));
   end

endmodule

// File: rtl/comparison_sequencer.sv
// Drives the shared comparison datapath for single ops or a four-op sweep,
// captures results and keeps a sticky error for width/consistency faults.
module comparison_sequencer
   import comparison_pkg::*;
#(
   parameter bit SWEEP_CHECK = 1'b1
)
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 sweep,
   input  logic [1:0]           op_in,
   input  logic [OPERAND_W-1:0] x_in,
   input  logic [OPERAND_W-1:0] y_in,
   output logic [OPERAND_W-1:0] cmp_x,
   output logic [OPERAND_W-1:0] cmp_y,
   output logic [1:0]           cmp_op,
   input  logic [RESULT_W-1:0]  cmp_result,
   output logic                 busy,
   output logic                 done,
   output logic [RESULT_W-1:0]  result,
   output logic                 eq_flag,
   output logic                 gt_flag,
   output logic                 lt_flag,
   output logic [OPERAND_W-1:0] max_val,
   output logic                 err,
   input  logic                 err_clr
);

   state_e state;
   logic   sweep_mode;
   logic   width_err;
   logic   cons_err;
   logic   err_set;

   comparison_checker u_checker (
      .eq_flag  (eq_flag),
      .gt_flag  (gt_flag),
      .lt_flag  (lt_flag),
      .max_val  (max_val),
      .x        (cmp_x),
      .y        (cmp_y),
      .cons_err (cons_err)
   );

   // Boolean ops may only use bit 0; MAX may only use the operand-width nibble.
   always_comb begin
      width_err = (cmp_op == OP_MAX) ? (|cmp_result[RESULT_W-1:OPERAND_W])
                                     : (|cmp_result[RESULT_W-1:1]);
      err_set   = ((state == EVAL) && width_err) || ((state == CHECK) && cons_err);
      busy      = (state != IDLE);
      done      = (state == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         sweep_mode <= 1'b0;
         cmp_x      <= '0;
         cmp_y      <= '0;
         cmp_op     <= OP_EQ;
         result     <= '0;
         eq_flag    <= 1'b0;
         gt_flag    <= 1'b0;
         lt_flag    <= 1'b0;
         max_val    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cmp_x      <= x_in;
                  cmp_y      <= y_in;
                  cmp_op     <= sweep ? OP_EQ : op_in;
                  sweep_mode <= sweep;
                  state      <= EVAL;
               end
            end
            EVAL: begin
               case (cmp_op)
                  OP_EQ:   eq_flag <= cmp_result[0];
                  OP_GT:   gt_flag <= cmp_result[0];
                  OP_LT:   lt_flag <= cmp_result[0];
                  default: max_val <= cmp_result[OPERAND_W-1:0];
               endcase
               if (!sweep_mode || (cmp_op == OP_MAX))
                  result <= cmp_result;
               if (!sweep_mode)
                  state <= DONE;
               else if (cmp_op == OP_MAX)
                  state <= SWEEP_CHECK ? CHECK : DONE;
               else
                  cmp_op <= cmp_op + 2'd1;
            end
            CHECK:   state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   // A fresh fault outranks a simultaneous clear so no violation is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         err <= 1'b0;
      else if (err_set)
         err <= 1'b1;
      else if (err_clr)
         err <= 1'b0;
   end

endmodule
